ysyx_23060278_ifu: RTL and testbench
====================================

YSYX_23060278_IFU -- requirements
Module: ysyx_23060278_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the value held in the address and inst_pc registers after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pc  input  32  fetch address driven by the core PC register.
REQ-005 SHALL have port pc_valid  input  1  core requests a fetch of pc.
REQ-006 SHALL have port pc_ready  output  1  IFU accepts pc this cycle.
REQ-007 SHALL have port flush  input  1  core discards any in-flight fetch (jal/jalr redirect).
REQ-008 SHALL have port araddr  output  32  memory read address.
REQ-009 SHALL have port arvalid  output  1  read address valid.
REQ-010 SHALL have port arready  input  1  memory accepts the address.
REQ-011 SHALL have port rdata  input  32  instruction word returned by memory.
REQ-012 SHALL have port rresp  input  2  response code; 2'b00 = OKAY, anything else = error.
REQ-013 SHALL have port rvalid  input  1  read data valid.
REQ-014 SHALL have port rready  output  1  IFU accepts read data.
REQ-015 SHALL have port inst  output  32  fetched instruction to the decoder.
REQ-016 SHALL have port inst_pc  output  32  address inst was fetched from.
REQ-017 SHALL have port inst_valid  output  1  inst/inst_pc/inst_fault valid.
REQ-018 SHALL have port inst_fault  output  1  fetch failed (misaligned pc or error response).
REQ-019 SHALL have port inst_ready  input  1  core consumes inst.

Function
REQ-020 SHALL implement FSM with states IDLE, AR, R, OUT; all outputs SHALL be decoded from state and registers only. No input-to-output combinational path.
REQ-021 IDLE: pc_ready=1. When pc_valid=1 and flush=0, capture pc into the address register. Go to OUT with fault=1 and inst=32'h0 if pc[1:0]!=0. Otherwise go to AR.
REQ-022 AR: arvalid=1, araddr=address register. On arready=1, go to R. araddr SHALL stay stable while arvalid=1 and arready=0.
REQ-023 R: rready=1. On rvalid=1, register rdata into inst, set fault=(rresp!=2'b00), then go to OUT.
REQ-024 OUT: inst_valid=1. On inst_ready=1, go to IDLE. inst, inst_pc and inst_fault SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-025 Minimum latency: with arready and rvalid asserted on first opportunity, pc accepted at cycle 0 → arvalid at 1 → rready at 2 → inst_valid at 3. Throughput: one fetch per 4 cycles.
REQ-026 Flush in IDLE: no capture.
REQ-027 Flush in OUT: drop inst_valid next cycle and go to IDLE.
REQ-028 Flush in AR or R: set a drop flag and complete the handshake in progress; no bus abort. When the data beat arrives, discard it, go to IDLE and clear the drop flag. inst_valid SHALL NOT assert for a dropped fetch.
REQ-029 Flush and inst_ready high in the same OUT cycle: flush wins, result is the same since both end in IDLE.
REQ-030 rvalid outside state R and arready outside state AR SHALL be ignored.

Reset
REQ-031 Asserting rst at any time, including mid-transaction, SHALL asynchronously force state=IDLE, arvalid=0, rready=0, inst_valid=0, inst=32'h0, inst_fault=0, drop flag=0, araddr=inst_pc=RESET_PC.
REQ-032 The first pc_ready=1 SHALL occur in the first cycle after rst deasserts.

Structure
REQ-033 The FSM state encoding, RESP_OKAY (2'b00) and the default RESET_PC SHALL live in shared package ysyx_23060278_pkg.
REQ-034 The block SHALL be one module with no sub-module; the memory model belongs to the bench.

Verification
REQ-035 pc=0x8000_0000, memory returns 0x0010_0093 with zero wait → inst_valid at cycle 3, inst=0x0010_0093, inst_pc=0x8000_0000, inst_fault=0.
REQ-036 arready delayed 3 cycles, rvalid delayed 2 cycles → araddr stable throughout, inst_valid at cycle 8, data correct.
REQ-037 pc=0x8000_0002 → no arvalid, inst_valid at cycle 1, inst_fault=1, inst=0.
REQ-038 rresp=2'b10 → inst_fault=1, inst=rdata, inst_pc correct.
REQ-039 Flush asserted in R → beat consumed, no inst_valid, IDLE next; next pc fetched normally.
REQ-040 rst asserted while arvalid=1 → arvalid=0 immediately (no clock edge needed), all outputs at reset values.

Source files
------------

// File: rtl/ysyx_23060278_pkg.sv
// Shared definitions for the ysyx_23060278 instruction fetch path.
package ysyx_23060278_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: accepts a pc from the core, performs one AXI-lite style
// read (AR then R channel) and presents the instruction word to the decoder.
module ysyx_23060278_ifu
  import ysyx_23060278_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        inst_fault,
  input  logic        inst_ready
);

  ifu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic        drop_q, drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= RESET_PC;
      inst_pc_q <= RESET_PC;
      inst_q    <= '0;
      fault_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      fault_q   <= fault_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    fault_d   = fault_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: begin
        if (pc_valid && !flush) begin
          addr_d    = pc;
          inst_pc_d = pc;
          if (pc[1:0] != 2'b00) begin
            inst_d  = '0;
            fault_d = 1'b1;
            state_d = OUT;
          end else begin
            state_d = AR;
          end
        end
      end
      AR: begin
        if (flush) drop_d = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        if (flush) drop_d = 1'b1;
        // A flush arriving with the beat itself also discards that beat.
        if (rvalid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            inst_d  = rdata;
            fault_d = (rresp != RESP_OKAY);
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (flush || inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_ready   = (state_q == IDLE);
  assign arvalid    = (state_q == AR);
  assign rready     = (state_q == R);
  assign inst_valid = (state_q == OUT);
  assign araddr     = addr_q;
  assign inst_pc    = inst_pc_q;
  assign inst       = inst_q;
  assign inst_fault = fault_q;

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// Directed-vector bench for ysyx_23060278_ifu with a small handshaking memory model.
module tb_ysyx_23060278_ifu;

  logic        clk, rst;
  logic [31:0] pc;
  logic        pc_valid, pc_ready, flush;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_fault, inst_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ysyx_23060278_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_fault(inst_fault), .inst_ready(inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int unsigned ar_dly;
    int unsigned r_dly;
    int unsigned out_hold;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int unsigned exp_lat;
    logic [31:0] exp_inst;
    logic        exp_fault;
    logic        exp_ar;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one fetch; cycle 0 is the cycle pc is presented in IDLE.
  task automatic run_fetch(input vec_t v);
    int unsigned cyc, w_ar, w_r;
    logic ar_seen, ar_ok, done, hold_ok;
    logic [31:0] h_inst, h_pc;
    logic h_fault;
    cyc = 0; w_ar = 0; w_r = 0;
    ar_seen = 1'b0; ar_ok = 1'b1; done = 1'b0; hold_ok = 1'b1;
    pc = v.pc; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0; cyc = 1;
    while (!done && cyc < 60) begin
      arready = 1'b0; rvalid = 1'b0; rdata = 32'hbad0_bad0; rresp = 2'b00;
      if (arvalid) begin
        ar_seen = 1'b1;
        if (araddr !== v.pc) ar_ok = 1'b0;
        arready = (w_ar >= v.ar_dly);
        w_ar++;
      end
      if (rready) begin
        rvalid = (w_r >= v.r_dly);
        if (rvalid) begin rdata = v.rdata; rresp = v.rresp; end
        w_r++;
      end
      if (inst_valid) begin
        check("latency", 32'(cyc), 32'(v.exp_lat));
        check("inst", inst, v.exp_inst);
        check("inst_pc", inst_pc, v.pc);
        check("inst_fault", {31'd0, inst_fault}, {31'd0, v.exp_fault});
        check("ar_seen", {31'd0, ar_seen}, {31'd0, v.exp_ar});
        check("araddr_stable", {31'd0, ar_ok}, 32'd1);
        h_inst = inst; h_pc = inst_pc; h_fault = inst_fault;
        for (int h = 0; h < int'(v.out_hold); h++) begin
          step();
          if (!inst_valid || inst !== h_inst || inst_pc !== h_pc || inst_fault !== h_fault)
            hold_ok = 1'b0;
        end
        if (v.out_hold > 0) check("out_hold_stable", {31'd0, hold_ok}, 32'd1);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("back_to_idle", {30'd0, pc_ready, inst_valid}, 32'd2);
        done = 1'b1;
      end else begin
        step();
        cyc++;
      end
    end
    arready = 1'b0; rvalid = 1'b0;
    if (!done) check("fetch_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 0, 0, 0, 32'h0010_0093, 2'b00, 3, 32'h0010_0093, 1'b0, 1'b1};
    vecs[1] = '{32'h8000_0004, 3, 2, 2, 32'h00a0_0513, 2'b00, 8, 32'h00a0_0513, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0002, 0, 0, 1, 32'h1111_1111, 2'b00, 1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0008, 1, 0, 0, 32'hdead_beef, 2'b10, 4, 32'hdead_beef, 1'b1, 1'b1};
    vecs[4] = '{32'h8000_000c, 0, 1, 0, 32'h1234_5678, 2'b01, 4, 32'h1234_5678, 1'b1, 1'b1};
    vecs[5] = '{32'h8000_0001, 0, 0, 0, 32'h2222_2222, 2'b00, 1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0010, 2, 0, 0, 32'h0000_0013, 2'b00, 5, 32'h0000_0013, 1'b0, 1'b1};
    vecs[7] = '{32'h8000_0014, 0, 0, 0, 32'h0000_8067, 2'b00, 3, 32'h0000_8067, 1'b0, 1'b1};

    rst = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0; inst_ready = 1'b0;
    #1;
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_araddr", araddr, 32'h8000_0000);
    check("rst_inst_pc", inst_pc, 32'h8000_0000);
    #11 rst = 1'b0;
    step();
    check("first_pc_ready", {31'd0, pc_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_fetch(vecs[i]);

    // flush while in R: beat consumed and discarded
    pc = 32'h8000_0010; pc_valid = 1'b1; step(); pc_valid = 1'b0;
    check("fr_arvalid", {31'd0, arvalid}, 32'd1);
    arready = 1'b1; step(); arready = 1'b0;
    check("fr_rready", {31'd0, rready}, 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check("fr_rready_hold", {30'd0, rready, inst_valid}, 32'd2);
    rvalid = 1'b1; rdata = 32'h5555_aaaa; rresp = 2'b00; step(); rvalid = 1'b0;
    check("fr_dropped", {30'd0, pc_ready, inst_valid}, 32'd2);
    step();
    check("fr_no_late_valid", {31'd0, inst_valid}, 32'd0);
    run_fetch(vecs[7]);

    // flush while in AR
    pc = 32'h8000_0018; pc_valid = 1'b1; step(); pc_valid = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("fa_ar_still", {31'd0, arvalid}, 32'd1);
    check("fa_araddr", araddr, 32'h8000_0018);
    arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h7777_7777; step(); rvalid = 1'b0;
    check("fa_dropped", {30'd0, pc_ready, inst_valid}, 32'd2);

    // flush while in OUT
    pc = 32'h8000_001c; pc_valid = 1'b1; step(); pc_valid = 1'b0;
    arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hcafe_f00d; rresp = 2'b11; step(); rvalid = 1'b0; rresp = 2'b00;
    check("fo_inst", inst, 32'hcafe_f00d);
    check("fo_fault", {30'd0, inst_valid, inst_fault}, 32'd3);
    flush = 1'b1; step(); flush = 1'b0;
    check("fo_dropped", {30'd0, pc_ready, inst_valid}, 32'd2);

    // flush in IDLE blocks capture; stray arready/rvalid are ignored
    pc = 32'h9000_0000; pc_valid = 1'b1; flush = 1'b1; step();
    pc_valid = 1'b0; flush = 1'b0;
    check("fi_no_capture", araddr, 32'h8000_001c);
    check("fi_idle", {29'd0, pc_ready, arvalid, inst_valid}, 32'd4);
    arready = 1'b1; rvalid = 1'b1; step(); step(); arready = 1'b0; rvalid = 1'b0;
    check("stray_ignored", {29'd0, pc_ready, rready, inst_valid}, 32'd4);

    // asynchronous reset in the middle of an AR handshake
    pc = 32'h8000_0020; pc_valid = 1'b1; step(); pc_valid = 1'b0;
    check("ra_arvalid", {31'd0, arvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ra_arvalid_clr", {31'd0, arvalid}, 32'd0);
    check("ra_araddr", araddr, 32'h8000_0000);
    check("ra_inst_pc", inst_pc, 32'h8000_0000);
    check("ra_inst", inst, 32'h0);
    check("ra_flags", {29'd0, rready, inst_valid, inst_fault}, 32'd0);
    check("ra_pc_ready", {31'd0, pc_ready}, 32'd1);
    rst = 1'b0;
    step();
    check("ra_after_release", {31'd0, pc_ready}, 32'd1);
    run_fetch(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
